// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: hex glyph table, blank code and digit-select
// classification used by the scan monitor and its decoder.
package seg7_pkg;

  // Active-high gfedcba glyphs, indexed by the nibble they display.
  localparam logic [6:0] SEG_PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Raw (active-low) bus value for an unlit digit.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    SEL_IDLE  = 2'd0,
    SEL_ONE   = 2'd1,
    SEL_MULTI = 2'd2
  } sel_kind_e;

  typedef struct packed {
    sel_kind_e  kind;
    logic [1:0] idx;
  } digit_sel_t;

  function automatic digit_sel_t classify_sel(input logic [3:0] ga_n);
    digit_sel_t r;
    r.kind = SEL_MULTI;
    r.idx  = 2'd0;
    case (~ga_n)
      4'b0000: r.kind = SEL_IDLE;
      4'b0001: begin r.kind = SEL_ONE; r.idx = 2'd0; end
      4'b0010: begin r.kind = SEL_ONE; r.idx = 2'd1; end
      4'b0100: begin r.kind = SEL_ONE; r.idx = 2'd2; end
      4'b1000: begin r.kind = SEL_ONE; r.idx = 2'd3; end
      default: r.kind = SEL_MULTI;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment glyph to hex nibble decoder (active-high pattern in).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] nibble_o,
  output logic       valid_o,
  output logic       blank_o
);

  logic [15:0] hit;

  for (genvar gi = 0; gi < 16; gi++) begin : g_match
    assign hit[gi] = (pat_i == SEG_PAT[gi]);
  end

  // Glyphs are distinct, so at most one hit is ever set.
  always_comb begin
    nibble_o = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (hit[i]) nibble_o = 4'(i);
    end
  end

  assign valid_o = |hit;
  assign blank_o = (pat_i == 7'h00);

endmodule

// File: rtl/seg_scan_capture.sv
// Monitors the multiplexed 7-segment bus, captures each stable digit dwell and
// assembles the four digits into a 16-bit frame with error reporting.
module seg_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  ga,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        changed,
  output logic        seg_err,
  output logic        sel_err
);

  localparam logic [7:0] STABLE    = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);

  logic [6:0]       s_seg_q;
  logic [3:0]       s_ga_q;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0][3:0]  slot_q, slot_d;
  logic [3:0]       mask_q, mask_d;
  logic             first_q, first_d;
  logic [15:0]      value_q, value_d;
  logic             fv_q, fv_d, ch_q, ch_d, seg_err_q, seg_err_d, sel_err_q, sel_err_d;

  logic [6:0]  pat_hi;
  logic [3:0]  dec_nibble;
  logic        dec_valid, dec_blank;
  logic        same, capture, frame;
  digit_sel_t  sel;

  assign pat_hi = ~seg;
  assign sel    = classify_sel(ga);

  seg7_decode u_dec (
    .pat_i    (pat_hi),
    .nibble_o (dec_nibble),
    .valid_o  (dec_valid),
    .blank_o  (dec_blank)
  );

  // The incoming sample is compared with the previously registered one, so the
  // STABLE_CYCLES-th identical sample captures on the edge that registers it.
  always_comb begin
    same      = (seg == s_seg_q) && (ga == s_ga_q);
    cnt_d     = !same ? 8'd1 : ((cnt_q >= STABLE) ? STABLE : cnt_q + 8'd1);
    capture   = same && (cnt_q == STABLE_M1) && (sel.kind == SEL_ONE);
    frame     = (mask_q == 4'hF);

    slot_d    = slot_q;
    mask_d    = frame ? 4'h0 : mask_q;
    if (capture && dec_valid) begin
      slot_d[sel.idx] = dec_nibble;
      mask_d[sel.idx] = 1'b1;
    end

    seg_err_d = capture && !dec_valid && !dec_blank;
    sel_err_d = !same && (sel.kind == SEL_MULTI);
    fv_d      = frame;
    ch_d      = frame && (first_q || (slot_q != value_q));
    value_d   = frame ? slot_q : value_q;
    first_d   = first_q && !frame;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg_q   <= SEG_BLANK;
      s_ga_q    <= 4'hF;
      cnt_q     <= 8'd0;
      slot_q    <= '0;
      mask_q    <= 4'h0;
      first_q   <= 1'b1;
      value_q   <= 16'h0;
      fv_q      <= 1'b0;
      ch_q      <= 1'b0;
      seg_err_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      s_seg_q   <= seg;
      s_ga_q    <= ga;
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      mask_q    <= mask_d;
      first_q   <= first_d;
      value_q   <= value_d;
      fv_q      <= fv_d;
      ch_q      <= ch_d;
      seg_err_q <= seg_err_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign value       = value_q;
  assign frame_valid = fv_q;
  assign changed     = ch_q;
  assign seg_err     = seg_err_q;
  assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed scenarios with literal expectations plus
// randomized dwells, all checked every cycle against a behavioural model.
module tb_seg_scan_capture;

  localparam int S = 4;
  localparam logic [6:0] PATS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  ga = 4'hF;
  logic [15:0] value;
  logic        frame_valid, changed, seg_err, sel_err;

  seg_scan_capture #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .ga          (ga),
    .value       (value),
    .frame_valid (frame_valid),
    .changed     (changed),
    .seg_err     (seg_err),
    .sel_err     (sel_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_fv = 0, n_ch = 0, n_serr = 0, n_selerr = 0;
  int last_fv_cyc = 0;
  int d0_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: counts run length of identical samples, captures on the
  // S-th one, and builds frames from a 4-entry slot array plus a seen-mask.
  logic [10:0] m_prev;
  int          m_run;
  logic [3:0]  m_slot [4];
  logic [3:0]  m_mask;
  logic        m_first;
  logic [15:0] m_value;
  logic        m_fv, m_ch, m_serr, m_selerr;

  always @(posedge clk or negedge rst_n) begin : model
    logic [10:0] smp;
    logic [15:0] flat;
    logic [6:0]  pat;
    int          dig, found;
    logic        newdwell;
    if (!rst_n) begin
      m_prev = {4'hF, 7'h7F};
      m_run = 0;
      for (int i = 0; i < 4; i++) m_slot[i] = 4'h0;
      m_mask = 4'h0; m_first = 1'b1; m_value = 16'h0;
      m_fv = 0; m_ch = 0; m_serr = 0; m_selerr = 0;
    end else begin
      smp = {ga, seg};
      newdwell = (smp != m_prev);
      m_run = newdwell ? 1 : m_run + 1;
      m_prev = smp;
      flat = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
      m_fv = (m_mask == 4'hF);
      m_ch = m_fv && (m_first || flat != m_value);
      if (m_fv) begin
        m_value = flat; m_first = 1'b0; m_mask = 4'h0;
      end
      m_selerr = newdwell && ($countones(~ga) >= 2);
      m_serr = 1'b0;
      if (m_run == S && $countones(~ga) == 1) begin
        dig = 0;
        for (int n = 0; n < 4; n++) if (!ga[n]) dig = n;
        pat = ~seg;
        found = -1;
        for (int i = 0; i < 16; i++) if (PATS[i] == pat) found = i;
        if (found >= 0) begin
          m_slot[dig] = 4'(found);
          m_mask[dig] = 1'b1;
        end else if (pat != 7'h00) begin
          m_serr = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("value", 32'(value), 32'(m_value));
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("changed", 32'(changed), 32'(m_ch));
    check("seg_err", 32'(seg_err), 32'(m_serr));
    check("sel_err", 32'(sel_err), 32'(m_selerr));
    if (frame_valid) begin n_fv++; last_fv_cyc = cyc; end
    if (changed) n_ch++;
    if (seg_err) n_serr++;
    if (sel_err) n_selerr++;
  end

  function automatic logic [3:0] sel_of(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  task automatic dwell(input logic [3:0] g, input logic [6:0] pat_hi, input int n);
    ga = g;
    seg = ~pat_hi;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [15:0] v, input int n);
    for (int d = 3; d >= 0; d--) begin
      if (d == 0) d0_start = cyc + 1;
      dwell(sel_of(d), PATS[v[4*d +: 4]], n);
    end
  endtask

  int b_fv, b_ch, b_serr, b_sel;
  task automatic mark();
    b_fv = n_fv; b_ch = n_ch; b_serr = n_serr; b_sel = n_selerr;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", 32'(value), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_pulses", {28'h0, changed, seg_err, sel_err, 1'b0}, 32'h0);
    rst_n = 1'b1;

    // Basic frame
    mark();
    scan(16'h1234, 8);
    dwell(4'hF, 7'h00, 2);
    check("basic_value", 32'(value), 32'h1234);
    check("basic_fv_count", 32'(n_fv - b_fv), 32'd1);
    check("basic_ch_count", 32'(n_ch - b_ch), 32'd1);
    check("basic_latency", 32'(last_fv_cyc - d0_start), 32'd4);

    // Repeated frame, then a different one
    mark();
    scan(16'h1234, 8);
    dwell(4'hF, 7'h00, 2);
    check("repeat_fv_count", 32'(n_fv - b_fv), 32'd1);
    check("repeat_ch_count", 32'(n_ch - b_ch), 32'd0);
    mark();
    scan(16'hABCD, 8);
    dwell(4'hF, 7'h00, 2);
    check("abcd_value", 32'(value), 32'hABCD);
    check("abcd_ch_count", 32'(n_ch - b_ch), 32'd1);

    // Short dwell on digit 2 must not capture
    mark();
    dwell(sel_of(2), PATS[5], 3);
    dwell(4'hF, 7'h00, 2);
    dwell(sel_of(3), PATS[9], 8);
    dwell(sel_of(1), PATS[8], 8);
    dwell(sel_of(0), PATS[7], 8);
    dwell(4'hF, 7'h00, 2);
    check("short_no_frame", 32'(n_fv - b_fv), 32'd0);
    dwell(sel_of(2), PATS[5], 8);
    dwell(4'hF, 7'h00, 2);
    check("short_then_frame", 32'(n_fv - b_fv), 32'd1);
    check("short_value", 32'(value), 32'h9587);

    // Invalid and blank patterns on digit 0
    mark();
    dwell(sel_of(3), PATS[1], 8);
    dwell(sel_of(2), PATS[2], 8);
    dwell(sel_of(1), PATS[3], 8);
    dwell(sel_of(0), 7'h49, 4);
    dwell(sel_of(0), 7'h00, 6);
    check("invalid_seg_err", 32'(n_serr - b_serr), 32'd1);
    check("invalid_no_frame", 32'(n_fv - b_fv), 32'd0);
    dwell(sel_of(0), PATS[7], 8);
    dwell(4'hF, 7'h00, 2);
    check("invalid_then_frame", 32'(n_fv - b_fv), 32'd1);
    check("invalid_value", 32'(value), 32'h1237);

    // Select errors
    mark();
    dwell(4'b1100, PATS[1], 8);
    dwell(4'b0000, PATS[1], 8);
    dwell(4'hF, 7'h00, 2);
    check("sel_err_count", 32'(n_selerr - b_sel), 32'd2);
    check("sel_err_no_frame", 32'(n_fv - b_fv), 32'd0);
    check("sel_err_value", 32'(value), 32'h1237);

    // Reset mid-frame
    dwell(sel_of(3), PATS[5], 8);
    dwell(sel_of(2), PATS[6], 8);
    rst_n = 1'b0;
    #1;
    check("midrst_value", 32'(value), 32'h0);
    check("midrst_pulses", {27'h0, frame_valid, changed, seg_err, sel_err, 1'b0}, 32'h0);
    ga = 4'hF; seg = 7'h7F;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mark();
    dwell(sel_of(1), PATS[0], 8);
    dwell(sel_of(0), PATS[0], 8);
    dwell(4'hF, 7'h00, 2);
    check("midrst_mask_cleared", 32'(n_fv - b_fv), 32'd0);
    scan(16'h0000, 8);
    dwell(4'hF, 7'h00, 2);
    check("midrst_fv_count", 32'(n_fv - b_fv), 32'd1);
    check("midrst_ch_count", 32'(n_ch - b_ch), 32'd1);
    check("midrst_value_zero", 32'(value), 32'h0);

    // Randomized dwells, checked cycle by cycle against the model
    for (int k = 0; k < 300; k++) begin
      int rg, rp;
      logic [3:0] g;
      logic [6:0] p;
      rg = $urandom_range(0, 9);
      rp = $urandom_range(0, 9);
      if (rg == 0)      g = 4'hF;
      else if (rg == 1) g = 4'($urandom);
      else              g = sel_of($urandom_range(0, 3));
      if (rp == 0)      p = 7'h00;
      else if (rp == 1) p = 7'($urandom);
      else              p = PATS[$urandom_range(0, 15)];
      dwell(g, p, $urandom_range(1, 10));
    end
    dwell(4'hF, 7'h00, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
